// File: rtl/demux_rr_dispatcher_pkg.sv
// demux_pkg: shared defaults and FSM state type for the round-robin demux dispatcher.
package demux_pkg;
    localparam int N_OUT_DEF = 4;
    localparam int SEL_W_DEF = $clog2(N_OUT_DEF);
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/demux_rr_dispatcher_rr_next_sel.sv
// rr_next_sel: picks the dispatch target from the rr pointer and sink readiness.
// DISPATCH_SKIP_BUSY_EN selects the skip-stalled-sink search; otherwise the pointer passes through.
module rr_next_sel
    import demux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_OUT-1:0] ready_i,
    output logic [SEL_W-1:0] idx_o
);
`ifdef DISPATCH_SKIP_BUSY_EN
    // Walk offsets from farthest to nearest so the closest ready sink wins.
    always_comb begin
        idx_o = ptr_i;
        for (int i = N_OUT - 1; i >= 0; i--)
            if (ready_i[ptr_i + SEL_W'(i)]) idx_o = ptr_i + SEL_W'(i);
    end
`else
    logic unused_ready;
    assign unused_ready = ^ready_i;
    assign idx_o = ptr_i;
`endif
endmodule

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: holds one source word and routes it round-robin to N_OUT sinks.
// Optional DISPATCH_SKIP_BUSY_EN (in rr_next_sel) skips sinks not ready at accept time.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic [N_OUT-1:0]  out_ready_i,
    output logic [N_OUT-1:0]  out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              busy_o
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, target;
    logic              deliver, accept;

    assign deliver    = (state_q == HOLD) && out_ready_i[sel_q];
    assign in_ready_o = rst_n && enable_i && ((state_q == IDLE) || deliver);
    assign accept     = in_valid_i && in_ready_o;
    assign ptr_d      = deliver ? sel_q + SEL_W'(1) : ptr_q;

    rr_next_sel #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_next_sel (
        .ptr_i   (ptr_d),
        .ready_i (out_ready_i),
        .idx_o   (target)
    );

    // When idle, sel tracks the pointer so it names the next strict target.
    always_comb begin
        state_d = accept ? HOLD : deliver ? IDLE : state_q;
        data_d  = accept ? in_data_i : data_q;
        sel_d   = accept ? target : deliver ? ptr_d : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_o = (state_q == HOLD) ? N_OUT'(1) << sel_q : '0;
    assign out_data_o  = data_q;
    assign sel_o       = sel_q;
    assign busy_o      = (state_q == HOLD);
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher: directed stimulus with a per-cycle behavioural model plus literal pins.
module tb_demux_rr_dispatcher;
    localparam int DW = 8;
    localparam int N  = 4;

    logic          clk = 0;
    logic          rst_n;
    logic          enable;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [N-1:0]  out_ready;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    sel;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    demux_rr_dispatcher #(.DATA_W(DW), .N_OUT(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .sel_o       (sel),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one optional held word, its sink, and the rr pointer.
    bit      m_hold;
    int      m_data, m_sink, m_ptr;
    bit      skip_mode;
    initial begin
`ifdef DISPATCH_SKIP_BUSY_EN
        skip_mode = 1;
`else
        skip_mode = 0;
`endif
    end

    function automatic int pick(int ptr, logic [N-1:0] rdy);
        if (skip_mode)
            for (int k = 0; k < N; k++)
                if (rdy[(ptr + k) % N]) return (ptr + k) % N;
        return ptr;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 0; m_data = 0; m_sink = 0; m_ptr = 0;
        end else begin
            bit done, take;
            done = m_hold && out_ready[m_sink];
            take = in_valid && enable && (!m_hold || done);
            if (done) m_ptr = (m_sink + 1) % N;
            if (take) begin
                m_hold = 1; m_data = int'(in_data); m_sink = pick(m_ptr, out_ready);
            end else if (done) m_hold = 0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] ev;
        ev = m_hold ? N'(1) << m_sink : '0;
        chk("m_out_valid", 32'(out_valid), 32'(ev));
        chk("m_busy", 32'(busy), 32'(m_hold));
        chk("m_out_data", 32'(out_data), 32'(m_data));
        if (m_hold || !rst_n) chk("m_sel", 32'(sel), 32'(m_sink));
        chk("m_in_ready", 32'(in_ready),
            32'(rst_n && enable && (!m_hold || out_ready[m_sink])));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 0; enable = 1; in_valid = 1; in_data = 8'hEE; out_ready = '0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        tick();
        rst_n = 1; in_valid = 0;
        tick();
        // Back-to-back stream, all sinks ready: one word per cycle, sel wraps.
        out_ready = 4'hF; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
            chk("stream_sel", 32'(sel), 32'(exp_sel[i]));
            chk("stream_data", 32'(out_data), 32'(8'hA0 + 8'(i)));
            chk("stream_in_ready", 32'(in_ready), 1);
        end
        in_valid = 0;
        tick();
        chk("stream_idle", 32'(busy), 0);
        // Stalled sink 1: word 0x55 held, next word waits at the source.
        out_ready = 4'b1101; in_valid = 1; in_data = 8'h55;
        tick();
        in_data = 8'h66;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'h2);
            chk("stall_data", 32'(out_data), 32'h55);
            chk("stall_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 4'hF;
        #1;
        chk("stall_release_ready", 32'(in_ready), 1);
        tick();
        chk("stall_next_sel", 32'(sel), 2);
        chk("stall_next_data", 32'(out_data), 32'h66);
        in_valid = 0;
        tick();
        // Hold on sink 3, a non-selected ready bit must not complete it.
        out_ready = '0; in_valid = 1; in_data = 8'h77;
        tick();
        in_valid = 0; out_ready = 4'b0100;
        tick();
        chk("ignore_valid", 32'(out_valid), 32'h8);
        chk("ignore_data", 32'(out_data), 32'h77);
        // enable=0 during HOLD: drain only.
        enable = 0; in_valid = 1; in_data = 8'h88;
        #1;
        chk("dis_in_ready", 32'(in_ready), 0);
        out_ready = 4'b1000;
        tick();
        chk("dis_drained", 32'(busy), 0);
        tick();
        chk("dis_still_idle", 32'(busy), 0);
        chk("dis_in_ready2", 32'(in_ready), 0);
        // Park the pointer at 1, then offer a word with only sinks 0 and 3 ready.
        enable = 1; out_ready = 4'hF; in_data = 8'h99;
        tick();
        in_valid = 0;
        tick();
        out_ready = 4'b1001; in_valid = 1; in_data = 8'hAA;
        tick();
        in_data = 8'hBB;
        chk("skip_sel", 32'(sel), skip_mode ? 3 : 1);
        tick();
        chk("skip_next_sel", 32'(sel), skip_mode ? 0 : 1);
        chk("skip_next_data", 32'(out_data), skip_mode ? 32'hBB : 32'hAA);
        // Reset while holding: everything clears immediately.
        out_ready = '0;
        tick();
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_sel", 32'(sel), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 0);
        tick();
        rst_n = 1; in_valid = 0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
